// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// This module controls the single write port of the 32x32 register file. Two
// sources share that port:
//   - A: the in-order writeback stage. It cannot be back-pressured, so it
//     always has priority.
//   - B: the multi-cycle load-response path, which uses a valid/ready
//     handshake.
// The module also keeps a scoreboard of registers that have loads outstanding.
// It raises a pipeline stall for RAW/WAW hazards against those registers, and
// also when B has waited too long for the port.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   a_valid, a_rd, a_data         writeback-stage result
//   b_valid, b_rd, b_data         load response
//   b_ready                       load response accepted this cycle
//   dec_rs1, dec_rs2, dec_rd      decode-stage register operands
//   issue_load                    decode issues a load to dec_rd
//   reg_wr, waddr, wdata          register-file write port
//   stall                         hold fetch/decode, insert a bubble
//   pending                       scoreboard bitmap (debug), bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  input  logic        issue_load,
  output logic        reg_wr,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] pending
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starve_q, starve_d;
  // out_en_q is cleared by reset and set on the first edge after release.
  // It keeps the combinational grant outputs at 0 until that edge, so every
  // output stays quiet through reset and across the release.
  logic             out_en_q;

  logic grant_a, grant_b, b_hs, b_starved, hazard, set_load;

  // ---------------------------------------------------------------------------
  // Arbitration: A has absolute priority, and B is granted only when A is idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_a = out_en_q & a_valid;
    grant_b = out_en_q & b_valid & ~a_valid;
    b_ready = grant_b;
    b_hs    = grant_b;            // b_valid & b_ready
    waddr   = 5'd0;
    wdata   = 32'd0;
    if (grant_a) begin
      waddr = a_rd;
      wdata = a_data;
    end else if (grant_b) begin
      waddr = b_rd;
      wdata = b_data;
    end
    // A grant to x0 is still consumed (a B handshake completes), but nothing
    // is written to the register file.
    reg_wr = (grant_a | grant_b) & (waddr != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Hazard detection. Bit 0 of the registered bitmap is never set, so lookups
  // at x0 return 0. A B writeback in the current cycle is deliberately not
  // bypassed into this check.
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard   = pending_q[dec_rs1] | pending_q[dec_rs2] | pending_q[dec_rd];
    stall    = hazard | starve_q;
    set_load = issue_load & ~stall & (dec_rd != 5'd0);
  end

  // ---------------------------------------------------------------------------
  // Scoreboard next state, computed per bit. When a bit is set and cleared in
  // the same cycle, the set wins: the newly issued load still needs its own
  // response.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_sb
      if (gi == 0) begin : g_x0
        assign pending_d[gi] = 1'b0;
      end else begin : g_bit
        assign pending_d[gi] = (set_load && (dec_rd == 5'(gi))) |
                               (pending_q[gi] & ~(b_hs && (b_rd == 5'(gi))));
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Starvation control. The counter tracks consecutive cycles in which B is
  // valid but not granted. The flag is set at the edge where the counter
  // reaches the limit, and it is held until B finally completes a handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    b_starved = out_en_q & b_valid & ~b_ready;
    cnt_d     = cnt_q;
    if (!b_valid || b_hs) begin
      cnt_d = '0;
    end else if (b_starved && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    starve_d = starve_q;
    if (b_hs) begin
      starve_d = 1'b0;
    end else if (b_starved && (cnt_d == LIMIT)) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q <= 32'd0;
      cnt_q     <= '0;
      starve_q  <= 1'b0;
      out_en_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      out_en_q  <= 1'b1;
    end
  end

  assign pending = pending_q;

  // The hazard stall must ensure that writeback never targets a register that
  // still has a load in flight.
  a_no_pending_write : assert property (
    @(posedge clk) disable iff (!reset_n)
      !(grant_a && (a_rd != 5'd0) && pending_q[a_rd]))
    else $error("writeback to register %0d with load pending", a_rd);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid, issue_load;
  logic [4:0]  a_rd, b_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] a_data, b_data;
  logic        b_ready, reg_wr, stall;
  logic [4:0]  waddr;
  logic [31:0] wdata, pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .issue_load(issue_load),
    .reg_wr(reg_wr), .waddr(waddr), .wdata(wdata),
    .stall(stall), .pending(pending)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Advance one clock: the inputs change and the outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; issue_load = 0;
  endtask

  typedef struct {
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        e_wr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_bready;
  } vec_t;

  vec_t vecs [8];

  initial begin
    // Arbitration vectors, all applied with an empty scoreboard.
    vecs[0] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0,         1'b0};
    vecs[1] = '{1'b1, 5'd3,  32'hAAAA_0001, 1'b1, 5'd4, 32'hBBBB_0002, 1'b1, 5'd3,  32'hAAAA_0001, 1'b0};
    vecs[2] = '{1'b0, 5'd3,  32'hAAAA_0001, 1'b1, 5'd4, 32'hBBBB_0002, 1'b1, 5'd4,  32'hBBBB_0002, 1'b1};
    vecs[3] = '{1'b1, 5'd0,  32'h0000_1234, 1'b0, 5'd0, 32'h0,         1'b0, 5'd0,  32'h0000_1234, 1'b0};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'h5555_AAAA, 1'b0, 5'd0,  32'h5555_AAAA, 1'b1};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0, 5'd6, 32'h1,         1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{1'b0, 5'd9,  32'hDEAD_BEEF, 1'b0, 5'd8, 32'hCAFE_F00D, 1'b0, 5'd0,  32'h0,         1'b0};
    vecs[7] = '{1'b1, 5'd1,  32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022, 1'b1, 5'd1,  32'h0000_0011, 1'b0};

    idle();
    reset_n = 0;
    #1;
    chk("reset_pending", pending, 32'h0);
    chk("reset_stall",   {31'd0, stall}, 32'd0);
    chk("reset_reg_wr",  {31'd0, reg_wr}, 32'd0);
    tick(); tick();
    #2 reset_n = 1;
    tick();

    // ---- table-driven arbitration ----
    for (int i = 0; i < 8; i++) begin
      a_valid = vecs[i].a_valid; a_rd = vecs[i].a_rd; a_data = vecs[i].a_data;
      b_valid = vecs[i].b_valid; b_rd = vecs[i].b_rd; b_data = vecs[i].b_data;
      #1;
      chk($sformatf("vec%0d_reg_wr", i),  {31'd0, reg_wr},  {31'd0, vecs[i].e_wr});
      chk($sformatf("vec%0d_waddr", i),   {27'd0, waddr},   {27'd0, vecs[i].e_addr});
      chk($sformatf("vec%0d_wdata", i),   wdata,            vecs[i].e_data);
      chk($sformatf("vec%0d_b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].e_bready});
      chk($sformatf("vec%0d_stall", i),   {31'd0, stall},   32'd0);
      tick();
    end
    idle();
    tick();

    // ---- load hazard ----
    dec_rd = 5; issue_load = 1;
    tick();
    issue_load = 0; dec_rd = 0;
    #1;
    chk("hz_pending_set", pending, 32'h0000_0020);
    dec_rs2 = 5;
    #1;
    chk("hz_stall_rs2", {31'd0, stall}, 32'd1);
    // A load issued while stalled must be ignored.
    issue_load = 1; dec_rd = 6;
    tick();
    issue_load = 0; dec_rd = 0;
    #1;
    chk("hz_no_set_when_stalled", pending, 32'h0000_0020);
    b_valid = 1; b_rd = 5; b_data = 32'h1234_5678;
    #1;
    chk("hz_b_ready",     {31'd0, b_ready}, 32'd1);
    chk("hz_stall_still", {31'd0, stall}, 32'd1);
    tick();
    b_valid = 0;
    #1;
    chk("hz_pending_clr", pending, 32'h0);
    chk("hz_stall_fall",  {31'd0, stall}, 32'd0);
    dec_rs2 = 0;

    // ---- starvation ----
    a_valid = 1; a_rd = 3; a_data = 32'h3;
    b_valid = 1; b_rd = 9; b_data = 32'h9;
    tick(); tick(); tick();
    chk("st_no_stall_at3", {31'd0, stall}, 32'd0);
    tick();
    chk("st_stall_at4", {31'd0, stall}, 32'd1);
    tick();
    chk("st_stall_held", {31'd0, stall}, 32'd1);
    a_valid = 0;
    #1;
    chk("st_b_ready",   {31'd0, b_ready}, 32'd1);
    chk("st_waddr",     {27'd0, waddr}, 32'd9);
    chk("st_stall_hs",  {31'd0, stall}, 32'd1);
    tick();
    b_valid = 0;
    #1;
    chk("st_stall_clr", {31'd0, stall}, 32'd0);

    // ---- x0 handling ----
    issue_load = 1; dec_rd = 0;
    tick();
    issue_load = 0;
    #1;
    chk("x0_pending", pending, 32'h0);

    // ---- set/clear collision on r7 ----
    b_valid = 1; b_rd = 7; b_data = 32'h7;
    issue_load = 1; dec_rd = 7;
    #1;
    chk("col_stall0",  {31'd0, stall}, 32'd0);
    chk("col_b_ready", {31'd0, b_ready}, 32'd1);
    tick();
    b_valid = 0; issue_load = 0; dec_rd = 0;
    #1;
    chk("col_pending", pending, 32'h0000_0080);
    b_valid = 1; b_rd = 7;
    tick();
    b_valid = 0;
    #1;
    chk("col_cleared", pending, 32'h0);

    // ---- reset in the middle of traffic ----
    dec_rd = 4; issue_load = 1;
    a_valid = 1; a_rd = 3; b_valid = 1; b_rd = 9;
    tick();
    issue_load = 0; dec_rd = 0;
    tick(); tick(); tick();
    chk("rst_pre_pending", pending, 32'h0000_0010);
    chk("rst_pre_stall",   {31'd0, stall}, 32'd1);
    #2;
    a_valid = 0;             // B alone would be granted if reset were not active
    reset_n = 0;
    #1;
    chk("rst_pending", pending, 32'h0);
    chk("rst_stall",   {31'd0, stall}, 32'd0);
    chk("rst_reg_wr",  {31'd0, reg_wr}, 32'd0);
    chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_waddr",   {27'd0, waddr}, 32'd0);
    tick();
    chk("rst_held_b_ready", {31'd0, b_ready}, 32'd0);
    #2 reset_n = 1;
    #1;
    chk("rst_rel_b_ready", {31'd0, b_ready}, 32'd0);
    chk("rst_rel_reg_wr",  {31'd0, reg_wr}, 32'd0);
    tick();
    chk("rst_after_b_ready", {31'd0, b_ready}, 32'd1);
    chk("rst_after_waddr",   {27'd0, waddr}, 32'd9);
    chk("rst_after_stall",   {31'd0, stall}, 32'd0);
    b_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
